regfile_stream_reader: RTL and testbench
========================================

# regfile_stream_reader

Downstream read engine for the append-only regfile buffer in the accelerator datapath. On `start` it walks a programmed address range through the regfile's random-read port and presents each word as a valid/ready stream for the next compute stage. It stalls on entries not yet written and on consumer back-pressure, and pulses `done` after the final beat is accepted.

## Interface
- `DATA_WIDTH`, 8, word width; must equal the regfile's `DATA_WIDTH`.
- `clk`  in  1  clock; every flop updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  12  first address, captured on `start`.
- `length`  in  13  number of words, 0..4096, captured on `start`.
- `abort`  in  1  cancels the current transfer.
- `wr_count`  in  13  number of regfile entries written so far (the regfile's write pointer).
- `ran_re`  out  1  regfile random-read enable.
- `ran_r_addr`  out  12  regfile random-read address.
- `ran_r_data`  in  DATA_WIDTH  regfile read data, combinational in the same cycle.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  consumer ready.
- `m_data`  out  DATA_WIDTH  beat data.
- `m_addr`  out  12  regfile address the beat came from.
- `m_last`  out  1  marks the final beat.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: waiting for `start`.
  - FETCH: issuing reads.
  - DRAIN: all reads issued; waiting for the last beat to be accepted.
- IDLE -> FETCH on `start` with `length` != 0. Captures `addr`=`base_addr` and `remaining`=`length`.
- `start` with `length`==0 stays in IDLE and pulses `done` the next cycle. No beats are produced.
- Output is a single register. It may load when `!m_valid || m_ready`; this condition is called `slot_free`.
- FETCH issue condition: `slot_free && addr < wr_count`. All three actions below happen combinationally in the issue cycle:
  - `ran_re`=1 and `ran_r_addr`=`addr`.
  - `ran_r_data` is captured into `m_data`, with `m_addr`=`addr`.
  - `m_last`=(`remaining`==1).
- On each issue: `addr` advances by the stride, modulo 4096. `remaining` decrements.
- When `remaining` reaches 0, FETCH -> DRAIN.
- When `addr >= wr_count` (data not yet written): `ran_re`=0 and FETCH holds. There is no timeout.
- `ran_re`=0 in all non-issue cycles. `ran_r_addr` holds its last value.
- `ran_r_data` is never consumed unless `ran_re`=1.
- DRAIN -> IDLE when the `m_last` beat completes its handshake (`m_valid && m_ready`). `done`=1 on the following cycle.
- `abort` in FETCH or DRAIN:
  - Next cycle: IDLE, `m_valid`=0, `m_last`=0.
  - No `done` pulse is generated.
  - `abort` has priority over `start` and over the handshake.
- `start` while `busy` is ignored.
- Address wrap: `addr`=4095 advances to 0. The availability check uses the wrapped address.

## Timing
- Reset values: every output is 0, including `ran_r_addr`, `m_data` and `m_addr`. State returns to IDLE.
- A reset asserted mid-transfer discards the transfer with no `done`.
- Latency: `start` at edge N puts the first issue in cycle N+1. The first `m_valid` is seen at N+2 if data is available.
- Throughput: one beat per cycle while `m_ready`=1 and data is available.
- `m_data`, `m_addr` and `m_last` are stable while `m_valid && !m_ready`.
- `done` is exactly one cycle wide. `busy` deasserts in the same cycle `done` asserts.

## Configuration
- Macro: `REGFILE_READER_STRIDE_EN`.
- Defined:
  - Adds input port `stride` (12 bits), captured on `start`.
  - Address step is `stride` modulo 4096.
  - `stride`=0 re-reads `base_addr` `length` times.
- Undefined:
  - No `stride` port.
  - Step is fixed at 1.

## Test plan
- Basic run: regfile filled with 0x10..0x17 (`wr_count`=8), `start` with `base_addr`=2, `length`=4, `m_ready`=1 -> beats 0x12, 0x13, 0x14, 0x15 on consecutive cycles, `m_last` on 0x15, then `done` one cycle later.
- Availability stall: `wr_count`=3, `base_addr`=0, `length`=5 -> 3 beats, then `ran_re`=0 and FETCH holds. Raise `wr_count` to 5 -> beats at addresses 3 and 4, then `done`.
- Back-pressure: toggle `m_ready` every other cycle -> no lost or duplicated beats, and outputs are stable while stalled.
- Boundaries:
  - `length`=0 -> `done` after 1 cycle with no `m_valid`.
  - `base_addr`=4094, `length`=3, `wr_count`=4096 -> addresses 4094, 4095, 0.
- Abort: `abort` mid-transfer, and separately `rst` mid-transfer -> IDLE next cycle, `m_valid`=0, no `done`. A following `start` runs correctly.
- With `REGFILE_READER_STRIDE_EN`: `stride`=3, `base_addr`=1, `length`=3 -> addresses 1, 4, 7.

Source files
------------

// File: rtl/regfile_stream_reader_if.sv
// regfile_stream_reader_if: valid/ready beat stream carrying a regfile word and its source address
// Signals: valid, ready, data[DATA_WIDTH], addr[12], last
// Modports: master (drives the beat, samples ready), slave (samples the beat, drives ready)
interface regfile_stream_reader_if #(parameter int DATA_WIDTH = 8);
  logic valid, ready, last;
  logic [DATA_WIDTH-1:0] data;
  logic [11:0] addr;
  modport master(output valid, data, addr, last, input ready);
  modport slave(input valid, data, addr, last, output ready);
endinterface

// File: rtl/regfile_stream_reader.sv
// regfile_stream_reader: walks an address range of an append-only regfile and streams the words out
// Ports: clk, rst (sync, active-high); start/base_addr/length launch a transfer; abort cancels it;
//   wr_count is the regfile write pointer; ran_re/ran_r_addr/ran_r_data form the random-read port;
//   m is the output beat stream; busy is high outside IDLE; done pulses once after the last beat.
// Option: REGFILE_READER_STRIDE_EN adds a 12-bit stride input (address step), otherwise the step is 1.
module regfile_stream_reader #(parameter int DATA_WIDTH = 8) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [11:0]           base_addr,
  input  logic [12:0]           length,
`ifdef REGFILE_READER_STRIDE_EN
  input  logic [11:0]           stride,
`endif
  input  logic                  abort,
  input  logic [12:0]           wr_count,
  output logic                  ran_re,
  output logic [11:0]           ran_r_addr,
  input  logic [DATA_WIDTH-1:0] ran_r_data,
  regfile_stream_reader_if.master m,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nx;
  logic [11:0] addr, last_addr, step;
  logic [12:0] remaining;
  logic slot_free, fire, issue, launch;
  assign slot_free = !m.valid || m.ready;
  assign fire = m.valid && m.ready;
  assign launch = state == IDLE && start;
`ifdef REGFILE_READER_STRIDE_EN
  always_ff @(posedge clk)
    if (rst) step <= '0;
    else if (launch) step <= stride;
`else
  assign step = 12'd1;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = launch && length != 13'd0 ? FETCH : IDLE;
    else if (abort) state_nx = IDLE;
    else if (state == FETCH) state_nx = issue && remaining == 13'd1 ? DRAIN : FETCH;
    else state_nx = fire && m.last ? IDLE : DRAIN;
  end
  // abort suppresses the read so no regfile word is consumed in a cancelled cycle
  always_comb begin
    busy = state != IDLE;
    issue = state == FETCH && !abort && slot_free && {1'b0, addr} < wr_count;
    ran_re = issue;
    ran_r_addr = issue ? addr : last_addr;
  end
  always_ff @(posedge clk)
    if (rst) begin
      addr <= '0;
      remaining <= '0;
      last_addr <= '0;
      done <= 1'b0;
      m.valid <= 1'b0;
      m.data <= '0;
      m.addr <= '0;
      m.last <= 1'b0;
    end else begin
      done <= (launch && length == 13'd0) || (state == DRAIN && !abort && fire && m.last);
      if (launch) begin
        addr <= base_addr;
        remaining <= length;
      end else if (issue) begin
        addr <= addr + step;
        remaining <= remaining - 13'd1;
      end
      if (issue) begin
        last_addr <= addr;
        m.valid <= 1'b1;
        m.data <= ran_r_data;
        m.addr <= addr;
        m.last <= remaining == 13'd1;
      end else if ((busy && abort) || fire) begin
        m.valid <= 1'b0;
        m.last <= 1'b0;
      end
    end
endmodule

// File: tb/tb_regfile_stream_reader.sv
// tb_regfile_stream_reader: table-driven and randomized checks of regfile_stream_reader against a queue model
module tb_regfile_stream_reader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] length = '0, wr_count = '0;
`ifdef REGFILE_READER_STRIDE_EN
  logic [11:0] stride = 12'd1;
`endif
  logic ran_re, busy, done;
  logic [11:0] ran_r_addr;
  logic [7:0] ran_r_data;
  logic [7:0] mem [4096];
  int checks = 0, failures = 0;

  regfile_stream_reader_if #(.DATA_WIDTH(8)) s();
  regfile_stream_reader #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
`ifdef REGFILE_READER_STRIDE_EN
    .stride(stride),
`endif
    .abort(abort), .wr_count(wr_count), .ran_re(ran_re), .ran_r_addr(ran_r_addr),
    .ran_r_data(ran_r_data), .m(s), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign ran_r_data = mem[ran_r_addr];

  typedef struct packed { logic [7:0] d; logic [11:0] a; logic l; } beat_t;
  typedef struct {
    logic [11:0] base; logic [12:0] len, wc1, wc2;
    int raise_at, mode, exp_beats, exp_first_valid;
    logic [7:0] exp_first_data; logic [11:0] exp_last_addr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // mode: 0 = always ready, 1 = ready every other cycle, 2 = random ready
  task automatic run(input logic [11:0] base, input logic [12:0] len, wc1, wc2,
                     input int raise_at, mode, step,
                     output int beats, first_valid, output logic [7:0] first_data, output logic [11:0] last_addr);
    beat_t q[$], e, held;
    int cyc = 0, dones = 0;
    bit fired_last = 1'b0, stalled = 1'b0, finished = 1'b0;
    beats = 0; first_valid = -1; first_data = '0; last_addr = '0;
    for (int i = 0; i < int'(len); i++) begin
      logic [11:0] a;
      a = 12'((int'(base) + i * step) % 4096);
      q.push_back('{d: mem[a], a: a, l: i == int'(len) - 1});
    end
    wr_count = wc1; base_addr = base; length = len; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (!finished && cyc < 5000) begin
      wr_count = cyc >= raise_at ? wc2 : wc1;
      s.ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled) chk("hold_beat", {s.valid, s.data, s.addr, s.last}, {1'b1, held});
      if (ran_re) chk("read_available", {1'b0, ran_r_addr} < wr_count, 1);
      if (q.size() != 0) chk("busy_active", busy, 1);
      if (s.valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        dones++;
        chk("done_timing", fired_last || (len == 0 && cyc == 0), 1);
        chk("done_busy_low", busy, 0);
        chk("done_all_beats", q.size(), 0);
      end else if (dones > 0) finished = 1'b1;
      fired_last = 1'b0;
      if (s.valid && s.ready) begin
        if (q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = q.pop_front();
          chk("beat", {s.data, s.addr, s.last}, e);
          if (beats == 0) first_data = s.data;
          last_addr = s.addr;
          beats++;
          fired_last = s.last;
        end
      end
      stalled = s.valid && !s.ready;
      held = {s.data, s.addr, s.last};
      @(posedge clk); #1; cyc++;
    end
    chk("no_timeout", finished, 1);
    chk("done_count", dones, 1);
    s.ready = 1'b0;
  endtask

  task automatic abort_seq(input logic [12:0] len, input int pre, input bit use_rst);
    wr_count = 13'd4096; base_addr = 12'd50; length = len; start = 1'b1; s.ready = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (pre) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1; rst = 1'b0; abort = 1'b0; start = 1'b0;
    @(negedge clk);
    chk(use_rst ? "rst_to_idle" : "abort_to_idle", {s.valid, s.last, busy, done}, 0);
    repeat (5) begin
      @(negedge clk);
      chk("no_done_after_cancel", {busy, done}, 0);
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs[6];
  int beats, fv;
  logic [7:0] fd;
  logic [11:0] la;

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    for (int a = 0; a < 8; a++) mem[a] = 8'(8'h10 + a);
    vecs[0] = '{12'd2,    13'd4,    13'd8,    13'd8,    0,  0, 4,    1,  8'h12,    12'd5};
    vecs[1] = '{12'd0,    13'd5,    13'd3,    13'd5,    12, 0, 5,    1,  8'h10,    12'd4};
    vecs[2] = '{12'd3,    13'd5,    13'd4096, 13'd4096, 0,  1, 5,    1,  8'h13,    12'd7};
    vecs[3] = '{12'd7,    13'd0,    13'd8,    13'd8,    0,  0, 0,    -1, 8'h00,    12'd0};
    vecs[4] = '{12'd4094, 13'd3,    13'd4096, 13'd4096, 0,  0, 3,    1,  mem[4094], 12'd0};
    vecs[5] = '{12'd100,  13'd4096, 13'd4096, 13'd4096, 0,  0, 4096, 1,  mem[100],  12'd99};
    s.ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {ran_re, ran_r_addr, s.valid, s.data, s.addr, s.last, busy, done}, 0);
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run(vecs[i].base, vecs[i].len, vecs[i].wc1, vecs[i].wc2, vecs[i].raise_at, vecs[i].mode, 1, beats, fv, fd, la);
      chk($sformatf("vec%0d_beats", i), beats, vecs[i].exp_beats);
      chk($sformatf("vec%0d_first_valid", i), fv, vecs[i].exp_first_valid);
      chk($sformatf("vec%0d_first_data", i), fd, vecs[i].exp_first_data);
      chk($sformatf("vec%0d_last_addr", i), la, vecs[i].exp_last_addr);
    end
    abort_seq(13'd20, 3, 1'b0);
    abort_seq(13'd1, 2, 1'b0);
    abort_seq(13'd20, 3, 1'b1);
    run(vecs[0].base, vecs[0].len, vecs[0].wc1, vecs[0].wc2, 0, 0, 1, beats, fv, fd, la);
    chk("after_cancel_beats", beats, 4);
    chk("after_cancel_last_addr", la, 12'd5);
`ifdef REGFILE_READER_STRIDE_EN
    stride = 12'd3;
    run(12'd1, 13'd3, 13'd8, 13'd8, 0, 0, 3, beats, fv, fd, la);
    chk("stride3_beats", beats, 3);
    chk("stride3_last_addr", la, 12'd7);
    stride = 12'd0;
    run(12'd6, 13'd4, 13'd8, 13'd8, 0, 1, 0, beats, fv, fd, la);
    chk("stride0_beats", beats, 4);
    chk("stride0_last_addr", la, 12'd6);
    stride = 12'd1;
`endif
    for (int i = 0; i < 25; i++) begin
      logic [12:0] len;
      len = 13'($urandom_range(1, 40));
      run(12'($urandom_range(0, 4095)), len, 13'($urandom_range(0, 4096)), 13'd4096,
          $urandom_range(0, 30), 2, 1, beats, fv, fd, la);
      chk("random_beats", beats, len);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
